// File: rtl/shifter_pipe_nb.sv
// Pipelined barrel shifter with valid/ready flow control.
// Input register -> log2(WIDTH) mux stages (optional mid register) -> output register.
// A single global enable stalls the whole pipeline when the output is held.
module shifter_pipe_nb #(
   parameter  int WIDTH   = 32,
   parameter  int REG_MID = 1,
   localparam int SHW     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   shamt,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             op_err
);

   // Stages [0, MID) run before the optional mid register, [MID, SHW) after it.
   localparam int MID = SHW / 2;

   logic                   w_en;
   logic [WIDTH-1:0]       r_in_a;
   logic [SHW-1:0]         r_in_sh;
   logic [2:0]             r_in_op;
   logic                   r_in_v;
   logic [SHW:0][WIDTH-1:0] w_stg;
   logic [WIDTH-1:0]       w_mid_x;
   logic [SHW-1:MID]       w_mid_sh;
   logic [2:0]             w_mid_op;
   logic                   w_mid_v;
   logic [WIDTH-1:0]       r_y;
   logic                   r_zero;
   logic                   r_err;
   logic                   r_out_v;

   // Whole pipeline advances unless a result is waiting on a busy consumer.
   assign w_en      = !r_out_v || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r_out_v;
   assign y         = r_y;
   assign zero      = r_zero;
   assign op_err    = r_err;

   // Capture operand; only the valid bit needs a reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_v <= 1'b0;
      end else if (w_en) begin
         r_in_v  <= in_valid;
         r_in_a  <= a;
         r_in_sh <= shamt;
         r_in_op <= op;
      end
   end

   assign w_stg[0] = r_in_a;

   generate
      if (REG_MID != 0) begin : g_mid
         logic [WIDTH-1:0] r_mid_x;
         logic [SHW-1:MID] r_mid_sh;
         logic [2:0]       r_mid_op;
         logic             r_mid_v;
         // Mid-pipeline register: only the shamt bits still to be applied travel on.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_mid_v <= 1'b0;
            end else if (w_en) begin
               r_mid_v  <= r_in_v;
               r_mid_x  <= w_stg[MID];
               r_mid_sh <= r_in_sh[SHW-1:MID];
               r_mid_op <= r_in_op;
            end
         end
         assign w_mid_x  = r_mid_x;
         assign w_mid_sh = r_mid_sh;
         assign w_mid_op = r_mid_op;
         assign w_mid_v  = r_mid_v;
      end else begin : g_nomid
         assign w_mid_x  = w_stg[MID];
         assign w_mid_sh = r_in_sh[SHW-1:MID];
         assign w_mid_op = r_in_op;
         assign w_mid_v  = r_in_v;
      end

      for (genvar s = 0; s < SHW; s++) begin : g_stg
         localparam int K = 1 << s;
         logic [WIDTH-1:0] w_x;
         logic [WIDTH-1:0] w_y;
         logic             w_bit;
         logic [2:0]       w_op;
         if (s < MID) begin : g_lo
            assign w_x   = w_stg[s];
            assign w_bit = r_in_sh[s];
            assign w_op  = r_in_op;
         end else begin : g_hi
            assign w_x   = (s == MID) ? w_mid_x : w_stg[s];
            assign w_bit = w_mid_sh[s];
            assign w_op  = w_mid_op;
         end
         // One log-shifter stage: shift/rotate by K when this shamt bit is set.
         // SRA fill uses the current MSB, which every prior SRA stage has preserved.
         always_comb begin
            w_y = w_x;
            if (w_bit) begin
               case (w_op)
                  3'd0:    w_y = {w_x[WIDTH-1-K:0], {K{1'b0}}};
                  3'd1:    w_y = {{K{1'b0}}, w_x[WIDTH-1:K]};
                  3'd2:    w_y = {{K{w_x[WIDTH-1]}}, w_x[WIDTH-1:K]};
                  3'd3:    w_y = {w_x[WIDTH-1-K:0], w_x[WIDTH-1:WIDTH-K]};
                  3'd4:    w_y = {w_x[K-1:0], w_x[WIDTH-1:K]};
                  default: w_y = w_x;
               endcase
            end
         end
         assign w_stg[s+1] = w_y;
      end
   endgenerate

   // Output register: result, zero flag from the final stage, reserved-op flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_v <= 1'b0;
         r_y     <= '0;
         r_zero  <= 1'b1;
         r_err   <= 1'b0;
      end else if (w_en) begin
         r_out_v <= w_mid_v;
         r_y     <= w_stg[SHW];
         r_zero  <= (w_stg[SHW] == '0);
         r_err   <= (w_mid_op > 3'd4);
      end
   end

endmodule

// File: tb/tb_shifter_pipe_nb.sv
// Scoreboard bench for shifter_pipe_nb: main 32-bit instance with directed,
// back-pressure, reset and random traffic, plus a WIDTH x REG_MID sweep.
module tb_shifter_pipe_nb;

   typedef struct {
      logic [63:0] y;
      logic        zero;
      logic        err;
      int          cyc;
      bit          lat;
   } exp_t;

   logic        clk = 0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, zero, op_err;
   logic [31:0] a, y;
   logic [4:0]  shamt;
   logic [2:0]  op;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   sw_fin = 0;
   bit   sweep_go = 0;
   bit   prev_stall = 0;
   logic [33:0] prev_out;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shifter_pipe_nb #(.WIDTH(32), .REG_MID(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .shamt(shamt), .op(op), .out_valid(out_valid),
      .out_ready(out_ready), .y(y), .zero(zero), .op_err(op_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Reference: plain arithmetic on a 64-bit container, masked to w bits.
   function automatic logic [63:0] ref_shift(input logic [63:0] av, input int sh,
                                             input logic [2:0] o, input int w);
      logic [63:0] m, x, r;
      m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      x = av & m;
      case (o)
         3'd0: r = x << sh;
         3'd1: r = x >> sh;
         3'd2: begin r = x >> sh; if (x[w-1]) r = r | ~(m >> sh); end
         3'd3: r = (x << sh) | (x >> (w - sh));
         3'd4: r = (x >> sh) | (x << (w - sh));
         default: r = x;
      endcase
      return r & m;
   endfunction

   task automatic send(input logic [31:0] ia, input int ish, input logic [2:0] iop,
                       input logic [31:0] ey, input logic ez, input logic ee, input bit lat);
      exp_t e;
      bit   ok = 0;
      @(posedge clk); #1;
      in_valid = 1; a = ia; shamt = ish[4:0]; op = iop;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.y = {32'd0, ey}; e.zero = ez; e.err = ee; e.cyc = cyc; e.lat = lat;
            q.push_back(e);
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin total++; bad++; $display("FAIL accept_timeout act=0 exp=1"); end
   endtask

   task automatic send_rnd(input bit lat);
      logic [31:0] ra;
      int          rs;
      logic [2:0]  ro;
      logic [31:0] ry;
      ra = $urandom; rs = $urandom_range(0, 31); ro = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ra = 32'd0;
      ry = ref_shift({32'd0, ra}, rs, ro, 32)[31:0];
      send(ra, rs, ro, ry, ry == 0, ro > 3'd4, lat);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL drain_timeout left=%0d exp=0", q.size()); end
   endtask

   // Monitor: pop-and-compare on every handshake, plus stall hold checks.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) chk("stall_hold", {30'd0, y, zero, op_err}, {30'd0, prev_out});
         if (out_valid && !out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_out act=%h exp=none", y);
            end else begin
               e = q.pop_front();
               chk("y", {32'd0, y}, e.y);
               chk("zero", {63'd0, zero}, {63'd0, e.zero});
               chk("op_err", {63'd0, op_err}, {63'd0, e.err});
               if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {y, zero, op_err};
      end
   end

   // Parameter sweep instances, each with its own driver and monitor.
   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int W  = (g < 2) ? 8 : 64;
      localparam int RM = g % 2;
      localparam int SW = $clog2(W);
      logic          s_iv, s_ir, s_ov, s_or, s_z, s_e;
      logic [W-1:0]  s_a, s_y;
      logic [SW-1:0] s_sh;
      logic [2:0]    s_op;
      exp_t          sq[$];

      shifter_pipe_nb #(.WIDTH(W), .REG_MID(RM)) u_sw (
         .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir),
         .a(s_a), .shamt(s_sh), .op(s_op), .out_valid(s_ov),
         .out_ready(s_or), .y(s_y), .zero(s_z), .op_err(s_e)
      );

      initial begin
         exp_t e;
         s_iv = 0; s_or = 1; s_a = '0; s_sh = '0; s_op = '0;
         wait (sweep_go);
         for (int n = 0; n < 150; n++) begin
            @(posedge clk); #1;
            s_iv = ($urandom_range(0, 3) != 0);
            s_a  = W'({$urandom, $urandom});
            s_sh = SW'($urandom_range(0, W - 1));
            s_op = 3'($urandom_range(0, 7));
            @(negedge clk);
            if (s_iv && s_ir) begin
               e.y    = ref_shift(64'(s_a), int'(s_sh), s_op, W);
               e.zero = (e.y == 0);
               e.err  = (s_op > 3'd4);
               e.cyc  = cyc;
               e.lat  = 1;
               sq.push_back(e);
            end
         end
         @(posedge clk); #1;
         s_iv = 0;
         for (int t = 0; t < 20 && sq.size() != 0; t++) @(negedge clk);
         total++;
         if (sq.size() != 0) begin bad++; $display("FAIL sweep_drain W=%0d RM=%0d left=%0d", W, RM, sq.size()); end
         sw_fin++;
      end

      always @(negedge clk) begin
         exp_t e;
         if (!rst && s_ov && s_or) begin
            if (sq.size() == 0) begin
               total++; bad++;
               $display("FAIL sweep_unexpected W=%0d RM=%0d act=%h", W, RM, s_y);
            end else begin
               e = sq.pop_front();
               chk($sformatf("sweep_y_W%0d_R%0d", W, RM), 64'(s_y), e.y);
               chk($sformatf("sweep_zero_W%0d_R%0d", W, RM), {63'd0, s_z}, {63'd0, e.zero});
               chk($sformatf("sweep_err_W%0d_R%0d", W, RM), {63'd0, s_e}, {63'd0, e.err});
               chk($sformatf("sweep_lat_W%0d_R%0d", W, RM), 64'(cyc - e.cyc), 64'(2 + RM));
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   logic [31:0] da [5];
   logic [31:0] dy [5];
   bit          rdone;

   initial begin
      rst = 1; in_valid = 0; out_ready = 1; a = '0; shamt = '0; op = '0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_y", {32'd0, y}, 64'd0);
      chk("rst_zero", {63'd0, zero}, 64'd1);
      chk("rst_op_err", {63'd0, op_err}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Basic modes on a fixed operand, expected values from the table.
      dy[0] = 32'h0000_0F10; dy[1] = 32'h0800_000F; dy[2] = 32'hF800_000F;
      dy[3] = 32'h0000_0F18; dy[4] = 32'h1800_000F;
      for (int i = 0; i < 5; i++) send(32'h8000_00F1, 4, 3'(i), dy[i], 1'b0, 1'b0, 1);
      idle(); drain();

      // Boundaries.
      for (int i = 0; i < 5; i++) da[i] = $urandom | 32'h1;
      for (int i = 0; i < 5; i++) send(da[i], 0, 3'(i), da[i], 1'b0, 1'b0, 1);
      send(32'h8000_0000, 31, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      send(32'h8000_0000, 31, 3'd1, 32'h0000_0001, 1'b0, 1'b0, 1);
      send(32'h0000_0001, 31, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 1);
      send(32'h8000_0000, 1,  3'd0, 32'h0000_0000, 1'b1, 1'b0, 1);
      // Reserved op then a legal op.
      send(32'h1234_5678, 5, 3'd6, 32'h1234_5678, 1'b0, 1'b1, 1);
      send(32'h1234_5678, 4, 3'd0, 32'h2345_6780, 1'b0, 1'b0, 1);
      idle(); drain();

      // Back-pressure: 8 ops with a 3-cycle stall mid-stream.
      fork
         begin
            for (int i = 0; i < 8; i++) send_rnd(0);
            idle();
         end
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1;
         end
      join
      drain();

      // Reset mid-flight: two accepted ops must never emerge.
      send(32'hDEAD_BEEF, 3, 3'd0, 32'h0, 1'b0, 1'b0, 0);
      send(32'hCAFE_F00D, 7, 3'd3, 32'h0, 1'b0, 1'b0, 0);
      @(posedge clk); #1;
      in_valid = 0; rst = 1;
      q.delete();
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_y", {32'd0, y}, 64'd0);
      chk("midrst_zero", {63'd0, zero}, 64'd1);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (6) @(negedge clk);

      // Random traffic with random back-pressure.
      rdone = 0;
      fork
         begin
            for (int i = 0; i < 60; i++) send_rnd(0);
            idle();
            rdone = 1;
         end
         begin
            while (!rdone) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
            out_ready = 1;
         end
      join
      drain();

      // Parameter sweep.
      sweep_go = 1;
      for (int t = 0; t < 1000 && sw_fin < 4; t++) @(negedge clk);
      total++;
      if (sw_fin < 4) begin bad++; $display("FAIL sweep_timeout act=%0d exp=4", sw_fin); end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
